// File: rtl/arb_pkg.sv
// Shared arbiter helpers: pointer sanitising and one-hot to binary encoding.
// Vectors are handled at ARB_MAX_W bits; callers zero-extend on the way in
// and truncate on the way out, so one function serves every WIDTH up to 64.
package arb_pkg;

  localparam int unsigned ARB_MAX_W = 64;
  localparam int unsigned ARB_IDX_W = 6;

  typedef logic [ARB_MAX_W-1:0] arb_vec_t;
  typedef logic [ARB_IDX_W-1:0] arb_idx_t;

  // Lowest set bit of vec; an all-zero vector selects bit 0.
  function automatic arb_vec_t sanitise_onehot(input arb_vec_t vec);
    arb_vec_t low;
    low = vec & (~vec + arb_vec_t'(1));
    if (vec == '0) low = arb_vec_t'(1);
    return low;
  endfunction

  // Binary index of a one-hot vector; zero input gives index 0.
  function automatic arb_idx_t onehot2idx(input arb_vec_t vec);
    arb_idx_t idx;
    idx = '0;
    for (int unsigned i = 0; i < ARB_MAX_W; i++) begin
      if (vec[i]) idx = idx | arb_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_fp_pick.sv
// Combinational wrap-around priority picker. prio must be one-hot; the
// winner is the first requester at or above the pointer, else the lowest
// requester below it.
module arb_fp_pick #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] vld,
  input  logic [WIDTH-1:0] prio,
  output logic [WIDTH-1:0] gnt
);

  logic [WIDTH-1:0] upper;
  logic [WIDTH-1:0] cand;

  // Mask off requesters below the pointer, fall back to all requesters
  // (the wrapped part of the scan), then isolate the lowest set bit.
  always_comb begin
    upper = vld & ~(prio - WIDTH'(1));
    cand  = (upper != '0) ? upper : vld;
    gnt   = cand & (~cand + WIDTH'(1));
  end

endmodule

// File: rtl/arb_fixed_prio.sv
// N-way priority arbiter with a programmable one-hot pointer and a
// registered one-hot grant. WIDTH must be in 2..64.
// Optional macro ARB_FP_GRANT_HOLD_EN: a granted requester keeps the grant
// for as long as it keeps requesting.
module arb_fixed_prio
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         v_vld,
  input  logic [WIDTH-1:0]         v_priority,
  output logic [WIDTH-1:0]         v_grant,
  output logic [$clog2(WIDTH)-1:0] grant_idx,
  output logic                     grant_any
);

  localparam int unsigned IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0] prio_clean;
  logic [WIDTH-1:0] pick_gnt;
  logic [WIDTH-1:0] grant_next;

  assign prio_clean = WIDTH'(sanitise_onehot(arb_vec_t'(v_priority)));

  arb_fp_pick #(
    .WIDTH (WIDTH)
  ) u_pick (
    .vld  (v_vld),
    .prio (prio_clean),
    .gnt  (pick_gnt)
  );

  // Next grant: fresh pick, or the current holder while it still requests.
  always_comb begin
`ifdef ARB_FP_GRANT_HOLD_EN
    grant_next = ((v_grant & v_vld) != '0) ? v_grant : pick_gnt;
`else
    grant_next = pick_gnt;
`endif
  end

  // Grant register with index and any-flag derived from the same next value.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_grant   <= '0;
      grant_idx <= '0;
      grant_any <= 1'b0;
    end else begin
      v_grant   <= grant_next;
      grant_idx <= IDX_W'(onehot2idx(arb_vec_t'(grant_next)));
      grant_any <= |grant_next;
    end
  end

`ifndef SYNTHESIS
  // Warn when more than one pointer bit is set (zero is a legal tie-off).
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(v_priority))
        else $warning("arb_fixed_prio: v_priority has multiple bits set, lowest used");
    end
  end
`endif

endmodule

// File: tb/tb_arb_fixed_prio.sv
// Directed-vector and randomised check of arb_fixed_prio at WIDTH=4.
module tb_arb_fixed_prio;

  logic       clk;
  logic       rst;
  logic [3:0] v_vld;
  logic [3:0] v_priority;
  logic [3:0] v_grant;
  logic [1:0] grant_idx;
  logic       grant_any;

  int checks;
  int errors;

  arb_fixed_prio #(
    .WIDTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .v_vld      (v_vld),
    .v_priority (v_priority),
    .v_grant    (v_grant),
    .grant_idx  (grant_idx),
    .grant_any  (grant_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [3:0] vld;
    logic [3:0] prio;
    logic [3:0] g;
    logic [1:0] idx;
    logic       any;
  } vec_t;

  vec_t tbl[$];

  // Independent reference: sanitise pointer, then walk p, p+1, ... wrapping.
  function automatic logic [3:0] ref_pick(input logic [3:0] vld, input logic [3:0] prio);
    int p;
    logic [3:0] r;
    p = 0;
    for (int i = 3; i >= 0; i--) if (prio[i]) p = i;
    r = 4'b0000;
    for (int k = 3; k >= 0; k--) if (vld[(p + k) % 4]) r = 4'b0001 << ((p + k) % 4);
    return r;
  endfunction

  function automatic logic [1:0] ref_idx(input logic [3:0] g);
    logic [1:0] ix;
    ix = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) ix = 2'(i);
    return ix;
  endfunction

  task automatic step(input logic r, input logic [3:0] vl, input logic [3:0] pr,
                      input logic [3:0] eg, input logic [1:0] ei, input logic ea,
                      input string nm);
    rst = r;
    v_vld = vl;
    v_priority = pr;
    @(posedge clk);
    #1;
    checks++;
    if (v_grant !== eg) begin
      errors++;
      $display("FAIL %s v_grant: got %b expected %b", nm, v_grant, eg);
    end
    checks++;
    if (grant_idx !== ei) begin
      errors++;
      $display("FAIL %s grant_idx: got %0d expected %0d", nm, grant_idx, ei);
    end
    checks++;
    if (grant_any !== ea) begin
      errors++;
      $display("FAIL %s grant_any: got %b expected %b", nm, grant_any, ea);
    end
  endtask

  logic [3:0] model_g;
  logic [3:0] exp_g;
  logic [3:0] rv;
  logic [3:0] rp;
  logic       hold_build;

  initial begin
    checks = 0;
    errors = 0;
`ifdef ARB_FP_GRANT_HOLD_EN
    hold_build = 1'b1;
`else
    hold_build = 1'b0;
`endif
    rst = 1'b1;
    v_vld = 4'b0000;
    v_priority = 4'b0000;

    //             rst   vld      prio     grant    idx    any
    tbl.push_back('{1'b1, 4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 4'b0001, 4'b0001, 2'd0, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b1011, 4'b0100, 4'b1000, 2'd3, 1'b1});
    tbl.push_back('{1'b0, 4'b0011, 4'b0100, 4'b0001, 2'd0, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b0110, 4'b0000, 4'b0010, 2'd1, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b0110, 4'b1010, 4'b0010, 2'd1, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 4'b1010, 4'b0000, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b1100, 4'b1010, 4'b0100, 2'd2, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b1000, 4'b0001, 4'b1000, 2'd3, 1'b1});
    tbl.push_back('{1'b1, 4'b1000, 4'b0001, 4'b0000, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b0110, 4'b1000, 4'b0010, 2'd1, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0});

    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].vld, tbl[i].prio, tbl[i].g, tbl[i].idx, tbl[i].any,
           $sformatf("vec%0d", i));
    end

    // Pointer moves while the holder keeps requesting, then holder drops.
    step(1'b0, 4'b0011, 4'b0001, 4'b0001, 2'd0, 1'b1, "hold_first");
    if (hold_build) step(1'b0, 4'b0011, 4'b0010, 4'b0001, 2'd0, 1'b1, "hold_keep");
    else            step(1'b0, 4'b0011, 4'b0010, 4'b0010, 2'd1, 1'b1, "prio_move");
    step(1'b0, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, "holder_drop");
    if (hold_build) step(1'b0, 4'b0011, 4'b0001, 4'b0010, 2'd1, 1'b1, "hold_again");
    else            step(1'b0, 4'b0011, 4'b0001, 4'b0001, 2'd0, 1'b1, "prio_back");
    step(1'b1, 4'b0011, 4'b0001, 4'b0000, 2'd0, 1'b0, "rst_mid");
    step(1'b0, 4'b0011, 4'b0001, 4'b0001, 2'd0, 1'b1, "rst_clears_hold");
    step(1'b0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0, "idle");

    // Random traffic against the reference model; pointer one-hot or zero.
    model_g = 4'b0000;
    for (int n = 0; n < 1000; n++) begin
      rv = 4'($urandom);
      rp = ($urandom_range(0, 7) == 0) ? 4'b0000 : (4'b0001 << $urandom_range(0, 3));
      exp_g = ref_pick(rv, rp);
      if (hold_build && ((model_g & rv) != 4'b0000)) exp_g = model_g;
      model_g = exp_g;
      step(1'b0, rv, rp, exp_g, ref_idx(exp_g), |exp_g, $sformatf("rand%0d", n));
      checks++;
      if (!$onehot0(v_grant)) begin
        errors++;
        $display("FAIL rand%0d onehot: got %b expected one-hot or zero", n, v_grant);
      end
      checks++;
      if ((v_grant & ~rv) != 4'b0000) begin
        errors++;
        $display("FAIL rand%0d subset: got %b expected within vld %b", n, v_grant, rv);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_fixed_prio.md
Name: arb_fixed_prio

Overview:
Parameterised N-way priority arbiter with a programmable one-hot priority pointer and a registered one-hot grant. Each cycle it picks exactly one requester from v_vld. The scan starts at the requester marked in v_priority and moves upward in index, wrapping around. It sits in front of shared resources such as buses, buffers and ports, and is the building block for round-robin arbiters, which drive v_priority externally.

Parameters:
WIDTH, 4, number of requesters (≥2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
v_vld  in  WIDTH  request vector, bit i = requester i is requesting
v_priority  in  WIDTH  one-hot pointer to the highest-priority requester
v_grant  out  WIDTH  registered one-hot grant, all-zero when no grant
grant_idx  out  $clog2(WIDTH)  binary index of the granted bit; 0 when v_grant is zero
grant_any  out  1  OR-reduction of v_grant

Behaviour:
- Reset (rst=1 at a clock edge): v_grant=0, grant_idx=0, grant_any=0. Reset has priority over all other inputs.
- Priority sanitising, combinational:
  - v_priority=0 → treated as bit 0 (lowest index highest priority). An unconnected or tied-low port therefore gives plain fixed priority with LSB wins.
  - More than one bit set → the lowest set bit is used.
- Selection, combinational: with pointer p, the winner is the first i in the order p, p+1, …, WIDTH-1, 0, …, p-1 with v_vld[i]=1.
- Suggested implementation: double-width mask-and-subtract, or an explicit rotate/priority-encode/rotate-back. Either is fine if it matches the selection rule.
- Latency: 1 cycle. v_grant at edge k+1 reflects v_vld and v_priority sampled at edge k.
- Grant is recomputed every cycle. There is no handshake and no grant lock in the base build.
- v_vld=0 → next v_grant=0 and grant_any=0.
- Invariants:
  - v_grant is always one-hot or zero.
  - v_grant is a subset of the v_vld sampled one cycle earlier.
- X on the inputs need not be handled. Assertions flag a non-one-hot v_priority in simulation only.

Optional Feature:
Macro ARB_FP_GRANT_HOLD_EN.
- Defined:
  - Once requester i is granted, the grant stays on i for as long as v_vld[i] stays 1, regardless of v_priority or other requests (lock/burst mode).
  - When v_vld[i] drops, arbitration resumes normally in that same cycle's evaluation, so the next grant appears at the following edge.
  - Reset clears the hold.
- Undefined: the grant is re-evaluated every cycle as described above.

Decomposition:
- Shared package arb_pkg:
  - function sanitise_onehot(vec) → lowest set bit, or bit 0 if the vector is zero.
  - function onehot2idx.
- Sub-module arb_fp_pick: purely combinational picker with inputs vld and prio, output one-hot gnt. It is reused by future round-robin wrappers.
- Top level: sanitiser, arb_fp_pick instance, grant register, index encode, optional hold logic.

Test Plan:
1. WIDTH=4, rst=1 for 2 cycles, v_vld=4'b1111 → v_grant=0 during reset; after reset with v_priority=4'b0001, v_grant=4'b0001 one cycle later, grant_idx=0.
2. v_priority=4'b0100, v_vld=4'b1011 → v_grant=4'b1000 (wraps from 2 to 3). Then v_vld=4'b0011 → v_grant=4'b0001.
3. v_priority=4'b0000 (unconnected), v_vld=4'b0110 → v_grant=4'b0010. v_priority=4'b1010 (invalid) → treated as 4'b0010.
4. v_vld=4'b0000 → v_grant=0, grant_any=0. Then v_vld=4'b1000 with v_priority=4'b0001 → v_grant=4'b1000, grant_idx=3.
5. Random v_vld and v_priority for 1000 cycles → scoreboard checks one-hot-or-zero, subset of previous v_vld, and the wrap-scan reference model.
6. ARB_FP_GRANT_HOLD_EN: v_vld=4'b0011 with v_priority=4'b0001 grants bit 0. Change v_priority to 4'b0010 → grant stays 4'b0001. Drop v_vld[0] → next grant is 4'b0010.
